// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_pkg: shared RV32 core types, opcodes and ALU op classes         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] c_op_nop   = 7'b0000000;
  localparam logic [6:0] c_op_r     = 7'b0110011;
  localparam logic [6:0] c_op_i     = 7'b0010011;
  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;
  localparam logic [6:0] c_op_beq   = 7'b1100011;

  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic       memreg;
    logic       memread;
    logic       memwrite;
    logic [1:0] aluop;
    logic       alusrc;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_detect: load-use hazard between the EX load and the ID reads   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hazard_detect (
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_ex_valid,
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  output logic       o_hazard
);

  logic w_rd_match;

  // rs2 is compared even for I-type; a spurious stall is cheaper than decoding here
  assign w_rd_match = (i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2);
  assign o_hazard   = i_id_valid & i_ex_valid & i_ex_memread &
                      (i_ex_rd != 5'd0) & w_rd_match;

endmodule
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter: event counter that sticks at all-ones                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + c_one;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_ex_stage: ID/EX pipeline register with load-use stall and bubbles |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module id_ex_stage #(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic             id_regwrite_i,
  input  logic             id_memreg_i,
  input  logic             id_memread_i,
  input  logic             id_memwrite_i,
  input  logic [1:0]       id_aluop_i,
  input  logic             id_alusrc_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [9:0]       id_funct_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             flush_i,
  input  logic             mem_stall_i,
  output logic             stall_o,
  output logic             ex_valid_o,
  output logic             ex_regwrite_o,
  output logic             ex_memreg_o,
  output logic             ex_memread_o,
  output logic             ex_memwrite_o,
  output logic             ex_alusrc_o,
  output logic [1:0]       ex_aluop_o,
  output logic [XLEN-1:0]  ex_rs1_data_o,
  output logic [XLEN-1:0]  ex_rs2_data_o,
  output logic [XLEN-1:0]  ex_imm_o,
  output logic [9:0]       ex_funct_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic [4:0]       ex_rd_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  import core_pkg::*;

  ctrl_t            w_id_ctrl;
  ctrl_t            r_ctrl;
  logic             r_valid;
  logic [XLEN-1:0]  r_rs1_data;
  logic [XLEN-1:0]  r_rs2_data;
  logic [XLEN-1:0]  r_imm;
  logic [9:0]       r_funct;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic             w_hazard;
  logic             w_bubble_inc;
  logic             w_stall_inc;

  always_comb begin
    w_id_ctrl = '0;
    if (id_valid_i) begin
      w_id_ctrl.regwrite = id_regwrite_i;
      w_id_ctrl.memreg   = id_memreg_i;
      w_id_ctrl.memread  = id_memread_i;
      w_id_ctrl.memwrite = id_memwrite_i;
      w_id_ctrl.aluop    = id_aluop_i;
      w_id_ctrl.alusrc   = id_alusrc_i;
    end
  end

  hazard_detect u_hazard_detect (
    .i_id_valid   (id_valid_i),
    .i_id_rs1     (id_rs1_i),
    .i_id_rs2     (id_rs2_i),
    .i_ex_valid   (r_valid),
    .i_ex_memread (r_ctrl.memread),
    .i_ex_rd      (r_rd),
    .o_hazard     (w_hazard)
  );

  // A frozen pipeline neither inserts nor counts anything, even with a hazard pending
  assign w_bubble_inc = ~mem_stall_i & (flush_i | w_hazard);
  assign w_stall_inc  = ~mem_stall_i & w_hazard;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_funct    <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else if (!mem_stall_i) begin
      if (flush_i || w_hazard) begin
        r_valid    <= 1'b0;
        r_ctrl     <= '0;
        r_rs1_data <= '0;
        r_rs2_data <= '0;
        r_imm      <= '0;
        r_funct    <= '0;
        r_rs1      <= '0;
        r_rs2      <= '0;
        r_rd       <= '0;
      end else begin
        r_valid    <= id_valid_i;
        r_ctrl     <= w_id_ctrl;
        r_rs1_data <= id_rs1_data_i;
        r_rs2_data <= id_rs2_data_i;
        r_imm      <= id_imm_i;
        r_funct    <= id_funct_i;
        r_rs1      <= id_rs1_i;
        r_rs2      <= id_rs2_i;
        r_rd       <= id_rd_i;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_inc   (w_stall_inc),
    .o_count (stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_inc   (w_bubble_inc),
    .o_count (bubble_cnt_o)
  );

  assign stall_o       = w_hazard;
  assign ex_valid_o    = r_valid;
  assign ex_regwrite_o = r_ctrl.regwrite;
  assign ex_memreg_o   = r_ctrl.memreg;
  assign ex_memread_o  = r_ctrl.memread;
  assign ex_memwrite_o = r_ctrl.memwrite;
  assign ex_alusrc_o   = r_ctrl.alusrc;
  assign ex_aluop_o    = r_ctrl.aluop;
  assign ex_rs1_data_o = r_rs1_data;
  assign ex_rs2_data_o = r_rs2_data;
  assign ex_imm_o      = r_imm;
  assign ex_funct_o    = r_funct;
  assign ex_rs1_o      = r_rs1;
  assign ex_rs2_o      = r_rs2;
  assign ex_rd_o       = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_id_ex_stage: scoreboard bench for the ID/EX register              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_id_ex_stage;

  import core_pkg::*;

  localparam int CW = 4;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memreg;
    logic        memread;
    logic        memwrite;
    logic [1:0]  aluop;
    logic        alusrc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [9:0]  funct;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } ins_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic id_valid_i = 1'b0, id_regwrite_i = 1'b0, id_memreg_i = 1'b0;
  logic id_memread_i = 1'b0, id_memwrite_i = 1'b0, id_alusrc_i = 1'b0;
  logic [1:0]  id_aluop_i = '0;
  logic [31:0] id_rs1_data_i = '0, id_rs2_data_i = '0, id_imm_i = '0;
  logic [9:0]  id_funct_i = '0;
  logic [4:0]  id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
  logic flush_i = 1'b0, mem_stall_i = 1'b0;

  logic stall_o, ex_valid_o, ex_regwrite_o, ex_memreg_o, ex_memread_o;
  logic ex_memwrite_o, ex_alusrc_o;
  logic [1:0]    ex_aluop_o;
  logic [31:0]   ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [9:0]    ex_funct_o;
  logic [4:0]    ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [CW-1:0] stall_cnt_o, bubble_cnt_o;

  id_ex_stage #(.XLEN(32), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_regwrite_i(id_regwrite_i), .id_memreg_i(id_memreg_i),
    .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i),
    .id_aluop_i(id_aluop_i), .id_alusrc_i(id_alusrc_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_funct_i(id_funct_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .flush_i(flush_i), .mem_stall_i(mem_stall_i), .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .ex_regwrite_o(ex_regwrite_o),
    .ex_memreg_o(ex_memreg_o), .ex_memread_o(ex_memread_o),
    .ex_memwrite_o(ex_memwrite_o), .ex_alusrc_o(ex_alusrc_o),
    .ex_aluop_o(ex_aluop_o), .ex_rs1_data_o(ex_rs1_data_o),
    .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
    .ex_funct_o(ex_funct_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
    .ex_rd_o(ex_rd_o), .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk = ~clk;

  ins_t w_ex;
  always_comb begin
    w_ex = '{valid: ex_valid_o, regwrite: ex_regwrite_o, memreg: ex_memreg_o,
             memread: ex_memread_o, memwrite: ex_memwrite_o, aluop: ex_aluop_o,
             alusrc: ex_alusrc_o, rs1d: ex_rs1_data_o, rs2d: ex_rs2_data_o,
             imm: ex_imm_o, funct: ex_funct_o, rs1: ex_rs1_o, rs2: ex_rs2_o,
             rd: ex_rd_o};
  end

  int   total = 0;
  int   bad   = 0;
  ins_t sb[$];
  ins_t held = '0;

  task automatic chk_ins(string name, ins_t act, ins_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk_val(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  function automatic ins_t mk(logic v, logic rw, logic mrg, logic mrd, logic mwr,
                              logic [1:0] op, logic src, logic [31:0] d1,
                              logic [31:0] d2, logic [31:0] im, logic [9:0] fn,
                              logic [4:0] s1, logic [4:0] s2, logic [4:0] d);
    return '{valid: v, regwrite: rw, memreg: mrg, memread: mrd, memwrite: mwr,
             aluop: op, alusrc: src, rs1d: d1, rs2d: d2, imm: im, funct: fn,
             rs1: s1, rs2: s2, rd: d};
  endfunction

  function automatic ins_t mask(ins_t in);
    ins_t m = in;
    if (!in.valid) begin
      m.regwrite = 1'b0;
      m.memreg   = 1'b0;
      m.memread  = 1'b0;
      m.memwrite = 1'b0;
      m.aluop    = 2'b00;
      m.alusrc   = 1'b0;
    end
    return m;
  endfunction

  task automatic drive(ins_t in, bit fl, bit ms);
    id_valid_i    = in.valid;
    id_regwrite_i = in.regwrite;
    id_memreg_i   = in.memreg;
    id_memread_i  = in.memread;
    id_memwrite_i = in.memwrite;
    id_aluop_i    = in.aluop;
    id_alusrc_i   = in.alusrc;
    id_rs1_data_i = in.rs1d;
    id_rs2_data_i = in.rs2d;
    id_imm_i      = in.imm;
    id_funct_i    = in.funct;
    id_rs1_i      = in.rs1;
    id_rs2_i      = in.rs2;
    id_rd_i       = in.rd;
    flush_i       = fl;
    mem_stall_i   = ms;
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(string name, ins_t in, bit fl, bit ms, bit exp_stall, bit cap);
    drive(in, fl, ms);
    #2;
    chk_val({name, "_stall"}, 32'(stall_o), 32'(exp_stall));
    if (cap) begin
      held = mask(in);
      if (in.valid) sb.push_back(held);
    end
    @(posedge clk);
    #1;
    if (!cap) begin
      if (ms) begin
        chk_ins({name, "_hold"}, w_ex, held);
      end else begin
        held = '0;
        chk_ins({name, "_bubble"}, w_ex, held);
      end
    end
  endtask

  task automatic chk_cnt(string name, int s, int b);
    chk_val({name, "_stall_cnt"},  32'(stall_cnt_o),  32'(s));
    chk_val({name, "_bubble_cnt"}, 32'(bubble_cnt_o), 32'(b));
  endtask

  // Monitor: every newly latched valid instruction must match the scoreboard head
  bit adv = 1'b0;
  always @(posedge clk) adv = !rst_i && !mem_stall_i;
  always @(negedge clk) begin
    if (adv && ex_valid_o) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ex_unexpected got=%h want=none", w_ex);
      end else begin
        chk_ins("ex_out", w_ex, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t add3, sub4, lw5, add6, lw0, add6x0, beq, sw, junk, lwl, nop;
    add3   = mk(1,1,0,0,0,c_aluop_funct,0, 32'd11, 32'd22, 32'd0,
                10'b0000000_000, 5'd1, 5'd2, 5'd3);
    sub4   = mk(1,1,0,0,0,c_aluop_funct,0, 32'd33, 32'd55, 32'd0,
                10'b0100000_000, 5'd3, 5'd5, 5'd4);
    lw5    = mk(1,1,1,1,0,c_aluop_add,1, 32'h1000, 32'd0, 32'd0,
                10'b0000000_010, 5'd1, 5'd0, 5'd5);
    add6   = mk(1,1,0,0,0,c_aluop_funct,0, 32'hABCD, 32'd22, 32'd0,
                10'b0000000_000, 5'd5, 5'd2, 5'd6);
    lw0    = mk(1,1,1,1,0,c_aluop_add,1, 32'h1000, 32'd0, 32'd0,
                10'b0000000_010, 5'd1, 5'd0, 5'd0);
    add6x0 = mk(1,1,0,0,0,c_aluop_funct,0, 32'd0, 32'd22, 32'd0,
                10'b0000000_000, 5'd0, 5'd2, 5'd6);
    beq    = mk(1,0,0,0,0,c_aluop_sub,0, 32'd7, 32'd7, 32'hFFFF_FFF0,
                10'b0000000_000, 5'd5, 5'd1, 5'd16);
    sw     = mk(1,0,0,0,1,c_aluop_add,1, 32'h2000, 32'hDEAD_BEEF, 32'd4,
                10'b0000000_010, 5'd1, 5'd2, 5'd4);
    junk   = mk(0,1,1,1,1,c_aluop_funct,1, 32'h5555_AAAA, 32'h1234_5678, 32'h9,
                10'h3FF, 5'd5, 5'd5, 5'd7);
    lwl    = mk(1,1,1,1,0,c_aluop_add,1, 32'h3000, 32'd0, 32'd8,
                10'b0000000_010, 5'd5, 5'd0, 5'd5);
    nop    = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_ins("reset_ex", w_ex, nop);
    chk_cnt("reset", 0, 0);
    rst_i = 1'b0;

    step("add", add3, 0, 0, 0, 1);
    step("sub", sub4, 0, 0, 0, 1);
    step("lw5", lw5, 0, 0, 0, 1);
    step("lu_stall", add6, 0, 0, 1, 0);
    step("lu_replay", add6, 0, 0, 0, 1);
    chk_cnt("load_use", 1, 1);

    step("lw0", lw0, 0, 0, 0, 1);
    step("x0_use", add6x0, 0, 0, 0, 1);
    chk_cnt("x0", 1, 1);

    step("lw5b", lw5, 0, 0, 0, 1);
    step("flush_hz", beq, 1, 0, 1, 0);
    chk_cnt("flush_hz", 2, 2);

    step("invalid", junk, 0, 0, 0, 1);
    chk_ins("invalid_ex", w_ex, mask(junk));
    chk_cnt("invalid", 2, 2);

    step("sw", sw, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step("freeze_sw", sub4, 0, 1, 0, 0);
    chk_cnt("freeze_sw", 2, 2);

    step("lw5c", lw5, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("freeze_hz", add6, 0, 1, 1, 0);
    chk_cnt("freeze_hz", 2, 2);
    step("thaw_hz", add6, 0, 0, 1, 0);
    step("thaw_replay", add6, 0, 0, 0, 1);
    chk_cnt("thaw", 3, 3);

    // Asynchronous reset between edges while a load sits in EX
    step("lw5d", lw5, 0, 0, 0, 1);
    #6;
    rst_i = 1'b1;
    #1;
    chk_ins("async_rst_ex", w_ex, nop);
    chk_val("async_rst_stall", 32'(stall_o), 32'd0);
    chk_cnt("async_rst", 0, 0);
    drive(nop, 0, 0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // lw x5,8(x5) back to back: every second cycle is a load-use bubble
    for (int k = 0; k < 40; k++) begin
      step("sat", lwl, 0, 0, bit'(k % 2), !bit'(k % 2));
      if (k == 27) chk_cnt("sat_14", 14, 14);
      if (k == 29) chk_cnt("sat_15", 15, 15);
    end
    chk_cnt("sat_hold", 15, 15);

    step("drain", nop, 0, 0, 0, 1);
    step("drain", nop, 0, 0, 0, 1);
    chk_val("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
